ws_array_sequencer: RTL

- Sequences one job on a ROWS x COLS weight-stationary systolic array.
- Preload: reads one weight row per cycle from weight memory and pulses the per-row weight-load enable.
- Stream: issues input-vector read addresses and enables.
- Collect: tracks pipeline latency to flag valid column outputs and their write addresses, then reports completion.
- Sits between the host/top-level control and the PE grid, input/weight SRAMs and output buffer.

---
 rtl/ws_array_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ws_array_sequencer.sv
// Job sequencer for a ROWS x COLS weight-stationary systolic array: weight preload, vector streaming, drain.
// Optional weight reuse across jobs is enabled by defining WS_SEQ_WEIGHT_REUSE_EN.
module ws_array_sequencer #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int VEC_W    = 8,
  parameter int PIPE_LAT = ROWS + COLS,
  localparam int AW      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [VEC_W-1:0] num_vectors,
`ifdef WS_SEQ_WEIGHT_REUSE_EN
  input  logic             keep_weights,
`endif
  output logic             busy,
  output logic             done,
  output logic             w_rd_en,
  output logic [AW-1:0]    w_addr,
  output logic [ROWS-1:0]  w_load,
  output logic             x_en,
  output logic [VEC_W-1:0] x_addr,
  output logic             y_valid,
  output logic [VEC_W-1:0] y_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state;
  logic [VEC_W-1:0]    k_reg;
  logic [PIPE_LAT-1:0] dl;
  logic                skip_load;

`ifdef WS_SEQ_WEIGHT_REUSE_EN
  logic weights_loaded;
  assign skip_load = keep_weights & weights_loaded;
`else
  assign skip_load = 1'b0;
`endif

  // The last delay-line stage is a flop, so y_valid is still a registered output.
  assign y_valid = dl[PIPE_LAT-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      k_reg   <= '0;
      dl      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      w_rd_en <= 1'b0;
      w_addr  <= '0;
      w_load  <= '0;
      x_en    <= 1'b0;
      x_addr  <= '0;
      y_addr  <= '0;
`ifdef WS_SEQ_WEIGHT_REUSE_EN
      weights_loaded <= 1'b0;
`endif
    end else begin
      dl     <= (dl << 1) | PIPE_LAT'(x_en);
      y_addr <= y_addr + VEC_W'(y_valid);
      // Weight memory returns the row one cycle after the read, so load follows the read by one.
      w_load <= w_rd_en ? (ROWS'(1) << w_addr) : '0;

      case (state)
        S_IDLE: begin
          if (start) begin
            k_reg  <= num_vectors;
            busy   <= 1'b1;
            w_addr <= '0;
            x_addr <= '0;
            y_addr <= '0;
            if (!skip_load) begin
              state   <= S_LOAD_W;
              w_rd_en <= 1'b1;
            end else if (num_vectors == '0) begin
              state <= S_DRAIN;
            end else begin
              state <= S_STREAM;
              x_en  <= 1'b1;
            end
          end
        end

        S_LOAD_W: begin
          if (w_rd_en) begin
            if (w_addr == AW'(ROWS - 1))
              w_rd_en <= 1'b0;
            else
              w_addr <= w_addr + AW'(1);
          end else begin
`ifdef WS_SEQ_WEIGHT_REUSE_EN
            weights_loaded <= 1'b1;
`endif
            if (k_reg == '0) begin
              state <= S_DRAIN;
            end else begin
              state <= S_STREAM;
              x_en  <= 1'b1;
            end
          end
        end

        S_STREAM: begin
          if (x_addr == k_reg - VEC_W'(1)) begin
            x_en  <= 1'b0;
            state <= S_DRAIN;
          end else begin
            x_addr <= x_addr + VEC_W'(1);
          end
        end

        S_DRAIN: begin
          // Leave once nothing remains behind the stage currently driving y_valid.
          if ((dl << 1) == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
